// File: rtl/block_stats_collector_pkg.sv
// Shared types and width helpers for the block statistics collector.
package block_stats_collector_pkg;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   localparam int unsigned DEF_DATA_WIDTH = 8;
   localparam int unsigned DEF_BLOCK_LEN  = 256;

   // Counter must hold BLOCK_LEN itself, hence the extra bit.
   function automatic int unsigned cnt_width(input int unsigned block_len);
      return $clog2(block_len) + 1;
   endfunction

   function automatic int unsigned sum_width(input int unsigned data_width,
                                             input int unsigned block_len);
      return data_width + $clog2(block_len);
   endfunction

endpackage

// File: rtl/block_stats_collector_if.sv
// Sample input stream and result-record handshake of the statistics collector.
interface block_stats_collector_if
   import block_stats_collector_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned BLOCK_LEN  = DEF_BLOCK_LEN
);
   localparam int unsigned CNT_WIDTH = cnt_width(BLOCK_LEN);
   localparam int unsigned SUM_WIDTH = sum_width(DATA_WIDTH, BLOCK_LEN);

   logic                  start;
   logic                  sample_valid;
   logic [DATA_WIDTH-1:0] sample_data;
   logic                  sample_last;
   logic                  rec_valid;
   logic                  rec_ready;
   logic [SUM_WIDTH-1:0]  rec_sum;
   logic [DATA_WIDTH-1:0] rec_min;
   logic [DATA_WIDTH-1:0] rec_max;
   logic [CNT_WIDTH-1:0]  rec_count;
   logic                  rec_len_err;
   logic                  overrun;
   logic                  busy;

   modport master (
      output start, sample_valid, sample_data, sample_last, rec_ready,
      input  rec_valid, rec_sum, rec_min, rec_max, rec_count, rec_len_err,
             overrun, busy
   );

   modport slave (
      input  start, sample_valid, sample_data, sample_last, rec_ready,
      output rec_valid, rec_sum, rec_min, rec_max, rec_count, rec_len_err,
             overrun, busy
   );

endinterface

// File: rtl/block_stats_collector_accum.sv
// Running sum/min/max/count over the current block; _c outputs include the present sample.
module block_stats_collector_accum
   import block_stats_collector_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned BLOCK_LEN  = DEF_BLOCK_LEN
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  clear,
   input  logic                                  accept,
   input  logic [DATA_WIDTH-1:0]                 data,
   output logic [sum_width(DATA_WIDTH, BLOCK_LEN)-1:0] sum_c,
   output logic [DATA_WIDTH-1:0]                 min_c,
   output logic [DATA_WIDTH-1:0]                 max_c,
   output logic [cnt_width(BLOCK_LEN)-1:0]       cnt_c
);
   localparam int unsigned CNT_WIDTH = cnt_width(BLOCK_LEN);
   localparam int unsigned SUM_WIDTH = sum_width(DATA_WIDTH, BLOCK_LEN);

   logic [SUM_WIDTH-1:0]  acc_sum;
   logic [DATA_WIDTH-1:0] acc_min;
   logic [DATA_WIDTH-1:0] acc_max;
   logic [CNT_WIDTH-1:0]  acc_cnt;

   assign sum_c = acc_sum + SUM_WIDTH'(data);
   assign min_c = (data < acc_min) ? data : acc_min;
   assign max_c = (data > acc_max) ? data : acc_max;
   assign cnt_c = acc_cnt + CNT_WIDTH'(1);

   // Clear wins over accept: a closing sample is folded into the record, not the next block.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_sum <= '0;
         acc_min <= '1;
         acc_max <= '0;
         acc_cnt <= '0;
      end else if (clear) begin
         acc_sum <= '0;
         acc_min <= '1;
         acc_max <= '0;
         acc_cnt <= '0;
      end else if (accept) begin
         acc_sum <= sum_c;
         acc_min <= min_c;
         acc_max <= max_c;
         acc_cnt <= cnt_c;
      end
   end

endmodule

// File: rtl/block_stats_collector.sv
// Per-block sum/min/max/count collector with a one-deep result register and sticky overrun flag.
module block_stats_collector
   import block_stats_collector_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned BLOCK_LEN  = DEF_BLOCK_LEN
) (
   input logic                    clk,
   input logic                    rst,
   block_stats_collector_if.slave bus
);
   localparam int unsigned CNT_WIDTH = cnt_width(BLOCK_LEN);
   localparam int unsigned SUM_WIDTH = sum_width(DATA_WIDTH, BLOCK_LEN);

   state_t state, state_next;

   logic [SUM_WIDTH-1:0]  sum_c;
   logic [DATA_WIDTH-1:0] min_c;
   logic [DATA_WIDTH-1:0] max_c;
   logic [CNT_WIDTH-1:0]  cnt_c;

   logic start_run, accept, hit_len, close, len_err_c, fire;

   logic                  rec_valid;
   logic [SUM_WIDTH-1:0]  rec_sum;
   logic [DATA_WIDTH-1:0] rec_min;
   logic [DATA_WIDTH-1:0] rec_max;
   logic [CNT_WIDTH-1:0]  rec_count;
   logic                  rec_len_err;
   logic                  overrun;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      start_run  = 1'b0;
      case (state)
         S_IDLE: if (bus.start) begin
            state_next = S_RUN;
            start_run  = 1'b1;
         end
         S_RUN:   state_next = S_RUN;
         default: state_next = S_IDLE;
      endcase
   end

   assign accept    = (state == S_RUN) && bus.sample_valid;
   assign hit_len   = (cnt_c == CNT_WIDTH'(BLOCK_LEN));
   assign close     = accept && (bus.sample_last || hit_len);
   assign len_err_c = !(bus.sample_last && hit_len);
   assign fire      = rec_valid && bus.rec_ready;

   block_stats_collector_accum #(
      .DATA_WIDTH (DATA_WIDTH),
      .BLOCK_LEN  (BLOCK_LEN)
   ) u_accum (
      .clk    (clk),
      .rst    (rst),
      .clear  (start_run || close),
      .accept (accept),
      .data   (bus.sample_data),
      .sum_c  (sum_c),
      .min_c  (min_c),
      .max_c  (max_c),
      .cnt_c  (cnt_c)
   );

   // A close can load only if the slot is empty or retiring this same edge; otherwise it is dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rec_valid   <= 1'b0;
         rec_sum     <= '0;
         rec_min     <= '0;
         rec_max     <= '0;
         rec_count   <= '0;
         rec_len_err <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         if (start_run) overrun <= 1'b0;
         if (close) begin
            if (!rec_valid || fire) begin
               rec_valid   <= 1'b1;
               rec_sum     <= sum_c;
               rec_min     <= min_c;
               rec_max     <= max_c;
               rec_count   <= cnt_c;
               rec_len_err <= len_err_c;
            end else begin
               overrun <= 1'b1;
            end
         end else if (fire) begin
            rec_valid <= 1'b0;
         end
      end
   end

   assign bus.rec_valid   = rec_valid;
   assign bus.rec_sum     = rec_sum;
   assign bus.rec_min     = rec_min;
   assign bus.rec_max     = rec_max;
   assign bus.rec_count   = rec_count;
   assign bus.rec_len_err = rec_len_err;
   assign bus.overrun     = overrun;
   assign bus.busy        = (state == S_RUN);

endmodule
